// File: rtl/mux_sel_arbiter_pkg.sv
// Shared constants and FSM state type for the mux select arbiter.
package mux_sel_arbiter_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    function automatic int cnt_width(input int max_burst);
        return (max_burst > 2) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_priority_pick.sv
// Rotating-priority encoder: first set req bit at or after ptr, modulo 4.
module rr_priority_pick
    import mux_sel_arbiter_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = ptr + SEL_W'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin burst arbiter driving the select of a downstream 4:1 mux.
module mux_sel_arbiter
    import mux_sel_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] grant,
    output logic              out_valid,
    output logic [NUM_CH-1:0] ack
);

    localparam int CNT_W = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_BURST - 1);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_found;
    logic              hit;

    rr_priority_pick u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        hit     = req[sel_q];
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                // Burst continues only on a transfer with the owner still asking.
                if (out_ready && hit && cnt_q != LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (out_ready || !hit) begin
                    state_d = IDLE;
                    ptr_d   = sel_q + 1'b1;
                end
            end
        endcase
        grant_d = (state_d == BUSY) ? (NUM_CH'(1) << sel_d) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end

    assign sel       = sel_q;
    assign grant     = grant_q;
    assign out_valid = (state_q == BUSY);
    assign ack       = (out_valid && out_ready) ? grant_q : '0;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed vector bench for mux_sel_arbiter (MAX_BURST=1 and MAX_BURST=4).
module tb_mux_sel_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       rdy;

    logic [1:0] sel1, sel4;
    logic [3:0] grant1, grant4, ack1, ack4;
    logic       ov1, ov4;

    int checks;
    int errors;

    typedef struct {
        logic       rst_before;
        logic       d;
        logic [3:0] req;
        logic       rdy;
        logic       ov;
        logic [1:0] sel;
        logic [3:0] ack;
    } vec_t;

    vec_t v[$];

    mux_sel_arbiter #(.MAX_BURST(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (rdy),
        .sel       (sel1),
        .grant     (grant1),
        .out_valid (ov1),
        .ack       (ack1)
    );

    mux_sel_arbiter #(.MAX_BURST(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (rdy),
        .sel       (sel4),
        .grant     (grant4),
        .out_valid (ov4),
        .ack       (ack4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk4(input string tag, input logic ov, input logic [1:0] s,
                        input logic [3:0] a);
        logic [3:0] g;
        g = ov ? (4'b0001 << s) : 4'b0000;
        chk({tag, ".out_valid"}, {3'b0, ov4}, {3'b0, ov});
        chk({tag, ".sel"}, {2'b0, sel4}, {2'b0, s});
        chk({tag, ".grant"}, grant4, g);
        chk({tag, ".ack"}, ack4, a);
    endtask

    task automatic chk1(input string tag, input logic ov, input logic [1:0] s,
                        input logic [3:0] a);
        logic [3:0] g;
        g = ov ? (4'b0001 << s) : 4'b0000;
        chk({tag, ".out_valid"}, {3'b0, ov1}, {3'b0, ov});
        chk({tag, ".sel"}, {2'b0, sel1}, {2'b0, s});
        chk({tag, ".grant"}, grant1, g);
        chk({tag, ".ack"}, ack1, a);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b1111;
        rdy = 1'b1;
        #1;
        chk1("rst_now", 1'b0, 2'd0, 4'b0000);
        chk4("rst_now", 1'b0, 2'd0, 4'b0000);
        @(negedge clk);
        chk1("rst_held", 1'b0, 2'd0, 4'b0000);
        chk4("rst_held", 1'b0, 2'd0, 4'b0000);
        rst = 1'b0;
        req = 4'b0000;
        rdy = 1'b0;
    endtask

    function automatic vec_t mk(input logic rb, input logic d,
                                input logic [3:0] r, input logic y,
                                input logic ov, input logic [1:0] s,
                                input logic [3:0] a);
        vec_t t;
        t.rst_before = rb;
        t.d   = d;
        t.req = r;
        t.rdy = y;
        t.ov  = ov;
        t.sel = s;
        t.ack = a;
        return t;
    endfunction

    initial begin
        logic [1:0] s;
        logic [3:0] a;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        req = 4'b0000;
        rdy = 1'b0;

        // MAX_BURST=1, all requesting: one grant per channel with bubbles.
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 1) begin
                s = 2'((k - 1) / 2);
                a = 4'b0001 << s;
                v.push_back(mk(k == 0, 1'b1, 4'b1111, 1'b1, 1'b1, s, a));
            end else begin
                s = (k == 0) ? 2'd0 : 2'(k / 2 - 1);
                v.push_back(mk(k == 0, 1'b1, 4'b1111, 1'b1, 1'b0, s, 4'b0));
            end
        end

        // MAX_BURST=4: bursts of four on 0 then 2.
        v.push_back(mk(1, 0, 4'b0101, 1, 0, 2'd0, 4'b0000));
        v.push_back(mk(0, 0, 4'b0101, 1, 1, 2'd0, 4'b0001));
        v.push_back(mk(0, 0, 4'b0101, 1, 1, 2'd0, 4'b0001));
        v.push_back(mk(0, 0, 4'b0101, 1, 1, 2'd0, 4'b0001));
        v.push_back(mk(0, 0, 4'b0101, 1, 1, 2'd0, 4'b0001));
        v.push_back(mk(0, 0, 4'b0101, 1, 0, 2'd0, 4'b0000));
        v.push_back(mk(0, 0, 4'b0101, 1, 1, 2'd2, 4'b0100));
        v.push_back(mk(0, 0, 4'b0101, 1, 1, 2'd2, 4'b0100));
        v.push_back(mk(0, 0, 4'b0101, 1, 1, 2'd2, 4'b0100));
        v.push_back(mk(0, 0, 4'b0101, 1, 1, 2'd2, 4'b0100));
        // Stalled grant on channel 1, then released.
        v.push_back(mk(0, 0, 4'b0010, 0, 0, 2'd2, 4'b0000));
        for (int k = 0; k < 5; k++)
            v.push_back(mk(0, 0, 4'b0010, 0, 1, 2'd1, 4'b0000));
        v.push_back(mk(0, 0, 4'b0010, 1, 1, 2'd1, 4'b0010));
        v.push_back(mk(0, 0, 4'b0000, 1, 1, 2'd1, 4'b0010));
        // Abort on channel 2 without ack, ptr moves to 3.
        v.push_back(mk(0, 0, 4'b0100, 0, 0, 2'd1, 4'b0000));
        v.push_back(mk(0, 0, 4'b0100, 0, 1, 2'd2, 4'b0000));
        v.push_back(mk(0, 0, 4'b0000, 0, 1, 2'd2, 4'b0000));
        v.push_back(mk(0, 0, 4'b1001, 0, 0, 2'd2, 4'b0000));
        v.push_back(mk(0, 0, 4'b1001, 1, 1, 2'd3, 4'b1000));
        v.push_back(mk(0, 0, 4'b0001, 1, 1, 2'd3, 4'b1000));
        // Get ptr back to 3, then wrap to channel 0.
        v.push_back(mk(0, 0, 4'b0100, 0, 0, 2'd3, 4'b0000));
        v.push_back(mk(0, 0, 4'b0100, 1, 1, 2'd2, 4'b0100));
        v.push_back(mk(0, 0, 4'b0000, 1, 1, 2'd2, 4'b0100));
        v.push_back(mk(0, 0, 4'b0001, 0, 0, 2'd2, 4'b0000));
        v.push_back(mk(0, 0, 4'b0001, 1, 1, 2'd0, 4'b0001));
        v.push_back(mk(0, 0, 4'b0000, 1, 1, 2'd0, 4'b0001));
        v.push_back(mk(0, 0, 4'b0000, 0, 0, 2'd0, 4'b0000));

        @(negedge clk);
        foreach (v[i]) begin
            if (v[i].rst_before) do_reset();
            req = v[i].req;
            rdy = v[i].rdy;
            #1;
            if (v[i].d)
                chk1($sformatf("v%0d", i), v[i].ov, v[i].sel, v[i].ack);
            else
                chk4($sformatf("v%0d", i), v[i].ov, v[i].sel, v[i].ack);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a channel-2 burst.
        do_reset();
        req = 4'b0100;
        rdy = 1'b1;
        #1;
        chk4("ar_idle", 1'b0, 2'd0, 4'b0000);
        @(negedge clk);
        #1;
        chk4("ar_busy", 1'b1, 2'd2, 4'b0100);
        #1;
        rst = 1'b1;
        #1;
        chk4("ar_async", 1'b0, 2'd0, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1000;
        rdy = 1'b0;
        #1;
        chk4("ar_rel", 1'b0, 2'd0, 4'b0000);
        @(negedge clk);
        #1;
        chk4("ar_grant3", 1'b1, 2'd3, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 The block SHALL have one parameter: MAX_BURST, default 4, meaning the maximum number of consecutive transfers granted to one channel (legal range 1..15).
REQ-002 The block SHALL have the port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have the port req  input  4  per-channel request; bit i corresponds to mux data input a/b/c/d for i=0/1/2/3.
REQ-005 The block SHALL have the port out_ready  input  1  downstream accepts the currently selected 4-bit mux output.
REQ-006 The block SHALL have the port sel  output  2  registered select driving the downstream 4:1 mux sel input.
REQ-007 The block SHALL have the port grant  output  4  registered one-hot grant; equals 1<<sel while out_valid=1, else 0.
REQ-008 The block SHALL have the port out_valid  output  1  registered; the mux output is valid.
REQ-009 The block SHALL have the port ack  output  4  combinational; ack = grant when out_valid and out_ready are both 1, else 0.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (out_valid=0) and BUSY (out_valid=1).
REQ-011 In IDLE with req!=0, the block SHALL enter BUSY next cycle, with sel set to the first requesting channel found scanning ptr, ptr+1, ... modulo 4, and burst_cnt set to 0.
REQ-012 In IDLE with req==0, the block SHALL remain in IDLE, holding sel and ptr.
REQ-013 Latency SHALL be exactly one cycle from req sampled high in IDLE to out_valid=1.
REQ-014 A transfer SHALL occur in any BUSY cycle where out_ready=1.
REQ-015 On a transfer with burst_cnt < MAX_BURST-1 and req[sel]=1, the block SHALL stay in BUSY with sel unchanged and burst_cnt incremented.
REQ-016 On a transfer with burst_cnt == MAX_BURST-1 or req[sel]=0, the block SHALL go to IDLE and set ptr = sel+1 modulo 4 (3 wraps to 0).
REQ-017 In BUSY without a transfer and req[sel]=0 (requester abort), the block SHALL go to IDLE with ptr = sel+1, and no ack SHALL be issued.
REQ-018 In BUSY without a transfer and req[sel]=1, the block SHALL hold all outputs and counters unchanged.
REQ-019 Every burst end SHALL produce exactly one IDLE bubble cycle before the next grant.
REQ-020 sel and grant SHALL NOT change while out_valid=1 unless the FSM leaves BUSY.
REQ-021 burst_cnt SHALL be ceil(log2(MAX_BURST)) bits wide, minimum 1, and SHALL never exceed MAX_BURST-1.
REQ-022 When MAX_BURST=1, every transfer SHALL return the FSM to IDLE.
REQ-023 Changes on req bits other than req[sel] while in BUSY SHALL have no effect until the next IDLE cycle.

Reset
REQ-024 While rst=1, the block SHALL immediately force state=IDLE, sel=0, grant=0, out_valid=0, ptr=0 and burst_cnt=0, independent of clk.
REQ-025 ack SHALL be 0 during reset, which follows from out_valid=0.
REQ-026 Reset asserted mid-burst SHALL abandon the burst without ack; after release, arbitration SHALL restart from ptr=0.

Structure
REQ-027 A shared package SHALL hold NUM_CH=4, SEL_W=2 and the FSM state enum (IDLE, BUSY).
REQ-028 One sub-module, rr_priority_pick, SHALL be used: a combinational rotating-priority encoder taking (req[3:0], ptr[1:0]) and returning (found, idx[1:0]).
REQ-029 All outputs except ack SHALL be driven from flops.

Verification
REQ-030 The bench SHALL cover: reset, then req=4'b1111 held, out_ready=1, MAX_BURST=1 -> sel sequence 0,1,2,3,0, each grant separated by one out_valid=0 cycle.
REQ-031 The bench SHALL cover: MAX_BURST=4, req=4'b0101 held, out_ready=1 -> four acks 4'b0001 on consecutive cycles, one bubble, then four acks 4'b0100.
REQ-032 The bench SHALL cover: req=4'b0010, out_ready=0 for 5 cycles -> out_valid=1, sel=1, ack=0 held stable; then out_ready=1 -> ack=4'b0010.
REQ-033 The bench SHALL cover: grant on channel 2 with out_ready=0, then req[2] dropped -> out_valid=0 next cycle with no ack; ptr=3, so req=4'b1001 next grants channel 3.
REQ-034 The bench SHALL cover: rst pulsed asynchronously mid-burst (between clk edges) -> out_valid, grant and sel go to 0 before the next edge; after release, req=4'b1000 grants sel=3 one cycle later.
REQ-035 The bench SHALL cover: ptr=3 with req=4'b0001 -> wrap-around grant of sel=0.
